// File: rtl/store_unit_if.sv
// ---------------------------------------------------------------------------
// store_unit_if
// Request/response handshake and memory-port bundle for store_unit.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface store_unit_if;
    logic        start;
    logic [1:0]  store_control;
    logic [31:0] addr;
    logic [31:0] reg_data;
    logic [31:0] mem_rd_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr;
    logic        busy;
    logic        done;
    logic        err;

    // Control unit / memory side
    modport master (
        output start, store_control, addr, reg_data, mem_rd_data,
        input  mem_addr, mem_wr_data, mem_wr, busy, done, err
    );

    // store_unit side
    modport slave (
        input  start, store_control, addr, reg_data, mem_rd_data,
        output mem_addr, mem_wr_data, mem_wr, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/store_unit.sv
// ---------------------------------------------------------------------------
// store_unit
// Merges register data into a memory word for sb/sh/sw. sb and sh perform a
// read-modify-write, sw writes directly. Sequenced by start/done.
// Optional feature macro: STORE_UNIT_LANE_EN (address-selected byte/halfword
// lanes, word-aligned memory address, misalignment error).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module store_unit #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    store_unit_if.slave bus
);

    localparam logic [1:0]       CODE_SB   = 2'd1;
    localparam logic [1:0]       CODE_SH   = 2'd2;
    localparam logic [1:0]       CODE_SW   = 2'd3;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [1:0]        ctrl_q;
    logic [15:0]       data_q;
    logic [31:0]       merged;
    logic [31:0]       req_mem_addr;
    logic              misaligned;
    logic              accept;
    logic              reject;
    logic              read_last;

    logic [31:0]       mem_addr_r;
    logic [31:0]       mem_wr_data_r;
    logic              mem_wr_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;

`ifdef STORE_UNIT_LANE_EN
    logic [1:0]        lane_q;

    // Word-aligned memory address and alignment check for the incoming request
    always_comb begin
        req_mem_addr = {bus.addr[31:2], 2'b00};
        misaligned   = ((bus.store_control == CODE_SH) && bus.addr[0]) ||
                       ((bus.store_control == CODE_SW) && (bus.addr[1:0] != 2'b00));
    end

    // Replace only the addressed byte/halfword lane of the read word
    always_comb begin
        merged = bus.mem_rd_data;
        if (ctrl_q == CODE_SB) begin
            case (lane_q)
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = data_q;
        end else begin
            merged[15:0]  = data_q;
        end
    end

    // Lane offset is kept separately because mem_addr is word-aligned
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q <= 2'b00;
        end else if (accept) begin
            lane_q <= bus.addr[1:0];
        end
    end
`else
    // Address passes through unchanged and is never alignment-checked
    always_comb begin
        req_mem_addr = bus.addr;
        misaligned   = 1'b0;
    end

    // Fixed low-lane merge
    always_comb begin
        merged = bus.mem_rd_data;
        if (ctrl_q == CODE_SB) begin
            merged[7:0]  = data_q[7:0];
        end else begin
            merged[15:0] = data_q;
        end
    end
`endif

    // Next-state, request accept/reject and latency counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        reject    = 1'b0;
        read_last = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if ((bus.store_control == 2'd0) || misaligned) begin
                        reject = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = (bus.store_control == CODE_SW) ? S_WRITE : S_READ;
                    end
                end
            end
            S_READ: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    read_last = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered outputs and captured request; outputs follow the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr_r    <= '0;
            mem_wr_data_r <= '0;
            mem_wr_r      <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            ctrl_q        <= 2'd0;
            data_q        <= '0;
        end else begin
            mem_wr_r <= (state_nxt == S_WRITE);
            busy_r   <= (state_nxt != S_IDLE);
            done_r   <= (state_nxt == S_DONE);
            err_r    <= reject;
            if (accept) begin
                mem_addr_r <= req_mem_addr;
                ctrl_q     <= bus.store_control;
                data_q     <= bus.reg_data[15:0];
                if (bus.store_control == CODE_SW) begin
                    mem_wr_data_r <= bus.reg_data;
                end
            end
            if (read_last) begin
                mem_wr_data_r <= merged;
            end
        end
    end

    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wr_data = mem_wr_data_r;
    assign bus.mem_wr      = mem_wr_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.err         = err_r;

endmodule

`default_nettype wire

// File: tb/tb_store_unit.sv
// ---------------------------------------------------------------------------
// tb_store_unit
// Scoreboard bench: two store_unit instances (MEM_LAT=1 and MEM_LAT=3) see
// identical requests; expected write/done/err events are queued per instance
// and popped by a monitor whenever the instance presents an event.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_word = 32'h1122_3344;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int          kind;   // 0 write, 1 done, 2 err
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    store_unit_if bus1 ();
    store_unit_if bus3 ();

    store_unit #(.MEM_LAT(1), .CNT_W(4)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    store_unit #(.MEM_LAT(3), .CNT_W(4)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

    assign bus1.mem_rd_data = mem_word;
    assign bus3.mem_rd_data = mem_word;

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected events
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic mon(input int id, input logic wr, input logic dn, input logic er,
                       input logic bsy, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   kind;
        if (!(wr || dn || er)) return;
        kind = wr ? 0 : (dn ? 1 : 2);
        checks++;
        if ((id == 1) ? (q1.size() == 0) : (q3.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_event dut%0d: kind=%0d addr=%h data=%h cyc=%0d, expected no event",
                     id, kind, a, d, cyc);
            return;
        end
        e = (id == 1) ? q1.pop_front() : q3.pop_front();
        if ((kind != e.kind) || (cyc != e.cyc) ||
            ((kind == 0) && ((a !== e.addr) || (d !== e.data))) ||
            ((kind == 2) && (bsy || wr))) begin
            errors++;
            $display("FAIL event dut%0d: got kind=%0d addr=%h data=%h cyc=%0d busy=%0b, expected kind=%0d addr=%h data=%h cyc=%0d",
                     id, kind, a, d, cyc, bsy, e.kind, e.addr, e.data, e.cyc);
        end
    endtask

    // Monitor: sample both instances away from the active edge
    always @(negedge clk) begin
        mon(1, bus1.mem_wr, bus1.done, bus1.err, bus1.busy, bus1.mem_addr, bus1.mem_wr_data);
        mon(3, bus3.mem_wr, bus3.done, bus3.err, bus3.busy, bus3.mem_addr, bus3.mem_wr_data);
    end

    // Issue one request at the current negedge; ek: 0 sw, 1 sb/sh, 2 err, 3 none expected.
    // The accept edge is the next posedge (cyc becomes a); spec cycle k is seen at cyc a+k-1.
    task automatic pulse(input logic [1:0] code, input logic [31:0] a, input logic [31:0] r,
                         input int ek, input logic [31:0] ea, input logic [31:0] ed);
        int acc;
        bus1.start = 1'b1; bus1.store_control = code; bus1.addr = a; bus1.reg_data = r;
        bus3.start = 1'b1; bus3.store_control = code; bus3.addr = a; bus3.reg_data = r;
        acc = cyc + 1;
        case (ek)
            0: begin
                q1.push_back('{0, ea, ed, acc});     q1.push_back('{1, 32'h0, 32'h0, acc + 1});
                q3.push_back('{0, ea, ed, acc});     q3.push_back('{1, 32'h0, 32'h0, acc + 1});
            end
            1: begin
                q1.push_back('{0, ea, ed, acc + 1}); q1.push_back('{1, 32'h0, 32'h0, acc + 2});
                q3.push_back('{0, ea, ed, acc + 3}); q3.push_back('{1, 32'h0, 32'h0, acc + 4});
            end
            2: begin
                q1.push_back('{2, 32'h0, 32'h0, acc});
                q3.push_back('{2, 32'h0, 32'h0, acc});
            end
            default: ;
        endcase
        @(negedge clk);
        bus1.start = 1'b0;
        bus3.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus1.busy || bus3.busy) && (n < 50)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still high after %0d cycles, expected idle", n);
        end
    endtask

    // Hard stop in case the bench itself stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus1.start = 1'b0; bus1.store_control = 2'd0; bus1.addr = '0; bus1.reg_data = '0;
        bus3.start = 1'b0; bus3.store_control = 2'd0; bus3.addr = '0; bus3.reg_data = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_mem_wr",   {31'd0, bus1.mem_wr}, 32'd0);
        chk("reset_busy",     {31'd0, bus1.busy},   32'd0);
        chk("reset_done",     {31'd0, bus1.done},   32'd0);
        chk("reset_err",      {31'd0, bus1.err},    32'd0);
        chk("reset_mem_addr", bus1.mem_addr,        32'd0);
        chk("reset_wr_data",  bus1.mem_wr_data,     32'd0);
        chk("reset_busy3",    {31'd0, bus3.busy},   32'd0);
        reset = 1'b1;
        @(negedge clk);

        // sw direct write
        pulse(2'd3, 32'h40, 32'hDEAD_BEEF, 0, 32'h40, 32'hDEAD_BEEF);
        wait_idle();
        // sb read-modify-write, low byte
        pulse(2'd1, 32'h40, 32'hAABB_CCDD, 1, 32'h40, 32'h1122_33DD);
        wait_idle();
        // sh read-modify-write, low halfword
        pulse(2'd2, 32'h40, 32'hAABB_CCDD, 1, 32'h40, 32'h1122_CCDD);
        wait_idle();
        // invalid code, then a valid sw accepted the very next cycle
        pulse(2'd0, 32'h44, 32'h0000_0001, 2, 32'h0, 32'h0);
        pulse(2'd3, 32'h44, 32'h1234_5678, 0, 32'h44, 32'h1234_5678);
        wait_idle();
        // start during READ with different data must be ignored
        pulse(2'd1, 32'h48, 32'h0000_00A5, 1, 32'h48, 32'h1122_33A5);
        pulse(2'd3, 32'h99, 32'hFFFF_FFFF, 3, 32'h0, 32'h0);
        wait_idle();
        // different memory contents
        mem_word = 32'hCAFE_F00D;
        pulse(2'd2, 32'h60, 32'h0000_1234, 1, 32'h60, 32'hCAFE_1234);
        wait_idle();
        mem_word = 32'h1122_3344;

        // reset asserted during READ abandons the store
        pulse(2'd2, 32'h50, 32'hAABB_CCDD, 3, 32'h0, 32'h0);
        #2 reset = 1'b0;
        #1;
        chk("midreset_mem_wr1",   {31'd0, bus1.mem_wr}, 32'd0);
        chk("midreset_busy1",     {31'd0, bus1.busy},   32'd0);
        chk("midreset_busy3",     {31'd0, bus3.busy},   32'd0);
        chk("midreset_mem_addr3", bus3.mem_addr,        32'd0);
        chk("midreset_wr_data3",  bus3.mem_wr_data,     32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);

`ifdef STORE_UNIT_LANE_EN
        pulse(2'd1, 32'h42, 32'hAABB_CCDD, 1, 32'h40, 32'h11DD_3344);
        wait_idle();
        pulse(2'd2, 32'h42, 32'hAABB_CCDD, 1, 32'h40, 32'hCCDD_3344);
        wait_idle();
        pulse(2'd3, 32'h41, 32'hDEAD_BEEF, 2, 32'h0, 32'h0);
        @(negedge clk);
        pulse(2'd2, 32'h43, 32'hAABB_CCDD, 2, 32'h0, 32'h0);
        @(negedge clk);
        chk("hold_mem_addr", bus1.mem_addr, 32'h40);
`else
        pulse(2'd1, 32'h42, 32'hAABB_CCDD, 1, 32'h42, 32'h1122_33DD);
        wait_idle();
        pulse(2'd2, 32'h42, 32'hAABB_CCDD, 1, 32'h42, 32'h1122_CCDD);
        wait_idle();
        pulse(2'd3, 32'h41, 32'hDEAD_BEEF, 0, 32'h41, 32'hDEAD_BEEF);
        wait_idle();
        pulse(2'd2, 32'h43, 32'hAABB_CCDD, 1, 32'h43, 32'h1122_CCDD);
        wait_idle();
        chk("hold_mem_addr", bus1.mem_addr, 32'h43);
`endif
        chk("hold_mem_addr3", bus3.mem_addr, bus1.mem_addr);

        repeat (10) @(negedge clk);
        chk("q1_drained", q1.size(), 32'd0);
        chk("q3_drained", q3.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
